// File: rtl/dmem_responder_if.sv
// Core-to-data-memory request/response bundle for dmem_responder.
// master = core side, slave = responder side.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-cycle stores, two-cycle loads with
// byte/half/word lanes and sign/zero extension, sticky access-error flag.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected (store dropped, load returns 0, err set) instead of force-aligned.
// BASE_ADDR is assumed word-aligned.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus_io
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {StIdle, StRdWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [29:0]     woff;
    logic [IdxW-1:0] idx;
    logic            in_range, is_byte, is_half, misaligned, mis_err, access_ok;
    logic            accept, mem_we;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [31:0]     mask, wrep, raw_word, mem_wdata, ext_data;
    logic [7:0]      ext_b;
    logic [15:0]     ext_h;

    // Address decode, lane selection and store merge for the presented request.
    always_comb begin
        woff     = bus_io.req_addr[31:2] - BASE_ADDR[31:2];
        in_range = (bus_io.req_addr[31:2] >= BASE_ADDR[31:2]) &&
                   ({2'b00, woff} < DEPTH_WORDS);
        idx      = woff[IdxW-1:0];
        is_byte  = (bus_io.req_size == 2'b00);
        is_half  = (bus_io.req_size == 2'b01);
        misaligned = (is_half && bus_io.req_addr[0]) ||
                     (!is_byte && !is_half && (bus_io.req_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
        mis_err  = misaligned;
`else
        mis_err  = 1'b0;
`endif
        access_ok = in_range && !mis_err;
        // Force-align: half drops bit 0, word drops both low bits.
        if (is_byte) begin
            lane = bus_io.req_addr[1:0];
            be   = 4'b0001 << lane;
            wrep = {4{bus_io.req_wdata[7:0]}};
        end else if (is_half) begin
            lane = {bus_io.req_addr[1], 1'b0};
            be   = 4'b0011 << lane;
            wrep = {2{bus_io.req_wdata[15:0]}};
        end else begin
            lane = 2'b00;
            be   = 4'b1111;
            wrep = bus_io.req_wdata;
        end
        mask      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        raw_word  = mem_q[idx];
        mem_wdata = (raw_word & ~mask) | (wrep & mask);
        accept    = bus_io.req_valid && (state_q == StIdle);
        mem_we    = accept && bus_io.req_we && access_ok && !rst;
    end

    // Extension of the latched load word according to latched size/lane/signedness.
    always_comb begin
        unique case (lane_q)
            2'd0:    ext_b = word_q[7:0];
            2'd1:    ext_b = word_q[15:8];
            2'd2:    ext_b = word_q[23:16];
            default: ext_b = word_q[31:24];
        endcase
        ext_h = lane_q[1] ? word_q[31:16] : word_q[15:0];
        if (size_q == 2'b00) begin
            ext_data = {{24{~uns_q & ext_b[7]}}, ext_b};
        end else if (size_q == 2'b01) begin
            ext_data = {{16{~uns_q & ext_h[15]}}, ext_h};
        end else begin
            ext_data = word_q;
        end
    end

    // Next-state logic for the load FSM, response data and error flag.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        size_d  = size_q;
        uns_d   = uns_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!access_ok) err_d = 1'b1;
                    if (!bus_io.req_we) begin
                        lane_d  = lane;
                        size_d  = bus_io.req_size;
                        uns_d   = bus_io.req_unsigned;
                        word_d  = access_ok ? raw_word : 32'h0;
                        state_d = StRdWait;
                    end
                end
            end
            StRdWait: begin
                rdata_d = ext_data;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus_io.req_ready = (state_q == StIdle);
    assign bus_io.rsp_valid = (state_q == StResp);
    assign bus_io.rsp_rdata = rdata_q;
    assign bus_io.err       = err_q;

    // Control/data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            lane_q  <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Data array: no reset, so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= mem_wdata;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the data array (power of two).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core presents an access this cycle.
REQ-006 req_ready  out  1  responder accepts an access this cycle; equals 1 only in IDLE.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-009 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_addr  in  32  byte address (core ALU output).
REQ-011 req_wdata  in  32  store data; byte/half taken from low bits.
REQ-012 rsp_valid  out  1  one-cycle pulse; rsp_rdata valid for a load.
REQ-013 rsp_rdata  out  32  extended load data (core read-data input).
REQ-014 err  out  1  sticky access-error flag.

Function
REQ-015 States SHALL be IDLE, RD_WAIT, RESP; accept condition = req_valid && req_ready.
REQ-016 Store accepted in IDLE SHALL write the selected lanes at that clock edge, stay in IDLE, and not assert rsp_valid.
REQ-017 Byte store SHALL write lane addr[1:0]; half store SHALL write lanes {addr[1],0} and {addr[1],1}; word store all four lanes; other lanes unchanged.
REQ-018 Load accepted in IDLE SHALL latch addr[1:0], size, unsigned and the array word, and move to RD_WAIT.
REQ-019 RD_WAIT SHALL last exactly one cycle, registering the extended data into rsp_rdata, then move to RESP.
REQ-020 RESP SHALL assert rsp_valid for exactly one cycle and return to IDLE; load latency = 2 cycles from accept edge to rsp_valid high.
REQ-021 rsp_rdata SHALL hold its last value outside RESP.
REQ-022 Extension: byte = lane addr[1:0] extended from bit 7; half = lanes selected by addr[1] extended from bit 15; word unmodified.
REQ-023 Word index = (addr - BASE_ADDR) >> 2; an address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) SHALL read 0, ignore writes, and set err.
REQ-024 req_valid while not IDLE SHALL be ignored (req_ready = 0); the core holds the request.
REQ-025 A load accepted the cycle after a store to the same word SHALL return the newly written data.
REQ-026 err SHALL stay set until rst.

Reset
REQ-027 When rst is 1 at a clock edge, the block SHALL enter IDLE and set rsp_valid = 0, rsp_rdata = 0, err = 0; req_ready = 1 the following cycle.
REQ-028 rst during RD_WAIT or RESP SHALL abort the load with no rsp_valid pulse.
REQ-029 Reset SHALL NOT clear array contents; a store presented in the reset cycle SHALL NOT write.

Configuration
REQ-030 Macro DMEM_MISALIGN_TRAP_EN defined: a half access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL suppress the write (store) or return 0 (load), set err, and keep normal load timing.
REQ-031 Macro DMEM_MISALIGN_TRAP_EN undefined: misaligned addresses SHALL be force-aligned (half clears bit 0, word clears bits 1:0) and complete normally without setting err.

Verification
REQ-032 Word store 0xDEADBEEF to 0x10, then load word 0x10 -> rsp_valid exactly 2 cycles after accept, rsp_rdata = 0xDEADBEEF.
REQ-033 Byte store 0x80 to 0x13, then signed byte load 0x13 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; load word 0x10 -> 0x80ADBEEF.
REQ-034 Half store 0x1234 to 0x22, then signed half load 0x22 -> 0x00001234; loads 0x20 and 0x22 both see unchanged lower half.
REQ-035 Second req_valid during RD_WAIT -> req_ready = 0, second request ignored until IDLE, then served with its own 2-cycle latency.
REQ-036 rst asserted during RD_WAIT -> no rsp_valid pulse, rsp_rdata = 0, err = 0, earlier stored word still readable.
REQ-037 Word load at 0x11 -> err = 1 and rsp_rdata = 0 with DMEM_MISALIGN_TRAP_EN; data of word 0x10 and err = 0 without it.
